// File: rtl/sextium_ctrl_gen.sv
// Sextium III microcode controller: fetch / slot-by-slot decode / execute with memory
// and IO handshakes, HALT and illegal-opcode flag. Optional ALU stall via CTRL_ALU_STALL_EN.
module sextium_ctrl_gen #(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        insn,
    input  logic              accz,
    input  logic              accn,
    input  logic              iobusy,
    input  logic              mem_ready,
    input  logic              alu_busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              ip_write,
    output logic              acc_write,
    output logic              seladdr,
    output logic [1:0]        selacc,
    output logic              selswap,
    output logic              doswap,
    output logic              selip1,
    output logic              selip2,
    output logic [SLOT_W-1:0] curinsn,
    output logic [1:0]        aluinsn,
    output logic              runio,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_FWAIT  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MWAIT  = 3'd3,
        ST_IOWAIT = 3'd4,
        ST_NEXT   = 3'd5,
        ST_HALT   = 3'd6,
        ST_AWAIT  = 3'd7
    } state_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              ir_write;
        logic              ip_write;
        logic              acc_write;
        logic              seladdr;
        logic [1:0]        selacc;
        logic              selswap;
        logic              doswap;
        logic              selip1;
        logic              selip2;
        logic [SLOT_W-1:0] curinsn;
        logic [1:0]        aluinsn;
        logic              runio;
        logic              halted;
        logic              illegal;
    } ctrl_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    state_t state_r, state_s;
    ctrl_t  out_r, out_s;

    // Next state and next registered control word; every field holds unless changed.
    always_comb begin
        state_s = state_r;
        out_s   = out_r;
        case (state_r)
            ST_FETCH: begin
                out_s.mem_read = 1'b1;
                out_s.ir_write = 1'b1;
                out_s.ip_write = 1'b1;
                out_s.seladdr  = 1'b0;
                out_s.selip1   = 1'b0;
                out_s.curinsn  = '0;
                state_s        = ST_FWAIT;
            end
            ST_FWAIT: begin
                out_s.ip_write = 1'b0;
                if (mem_ready) begin
                    out_s.mem_read = 1'b0;
                    out_s.ir_write = 1'b0;
                    state_s        = ST_DECODE;
                end else begin
                    state_s = ST_FWAIT;
                end
            end
            ST_DECODE: begin
                out_s.mem_read  = 1'b0;
                out_s.mem_write = 1'b0;
                out_s.ir_write  = 1'b0;
                out_s.ip_write  = 1'b0;
                out_s.acc_write = 1'b0;
                out_s.doswap    = 1'b0;
                out_s.runio     = 1'b0;
                out_s.illegal   = 1'b0;
                state_s         = ST_NEXT;
                case (insn)
                    4'd0: begin
                        state_s = ST_NEXT;
                    end
                    4'd1: begin
                        out_s.runio  = 1'b1;
                        out_s.selacc = 2'd1;
                        state_s      = ST_IOWAIT;
                    end
                    4'd2: begin
                        out_s.mem_read  = 1'b1;
                        out_s.acc_write = 1'b1;
                        out_s.selacc    = 2'd0;
                        out_s.seladdr   = 1'b1;
                        state_s         = ST_MWAIT;
                    end
                    4'd3: begin
                        out_s.mem_write = 1'b1;
                        out_s.seladdr   = 1'b1;
                        state_s         = ST_MWAIT;
                    end
                    4'd4, 4'd5: begin
                        out_s.acc_write = 1'b1;
                        out_s.selacc    = 2'd2;
                        out_s.doswap    = 1'b1;
                        out_s.selswap   = insn[0];
                    end
                    4'd6, 4'd7: begin
                        // A taken branch parks on the last slot so NEXT refetches.
                        if ((insn[0] == 1'b0) ? accz : accn) begin
                            out_s.ip_write = 1'b1;
                            out_s.selip1   = 1'b1;
                            out_s.selip2   = 1'b0;
                            out_s.curinsn  = LAST_SLOT;
                        end else begin
                            out_s.ip_write = 1'b0;
                        end
                    end
                    4'd8: begin
                        out_s.ip_write = 1'b1;
                        out_s.selip1   = 1'b1;
                        out_s.selip2   = 1'b1;
                        out_s.curinsn  = LAST_SLOT;
                    end
                    4'd9: begin
                        out_s.mem_read  = 1'b1;
                        out_s.acc_write = 1'b1;
                        out_s.selacc    = 2'd0;
                        out_s.seladdr   = 1'b0;
                        out_s.ip_write  = 1'b1;
                        out_s.selip1    = 1'b0;
                        state_s         = ST_MWAIT;
                    end
                    4'd10, 4'd11: begin
                        out_s.aluinsn   = insn[1:0] - 2'd2;
                        out_s.acc_write = 1'b1;
                        out_s.selacc    = 2'd3;
                    end
                    4'd12, 4'd13: begin
                        out_s.aluinsn = insn[1:0] - 2'd2;
                        out_s.selacc  = 2'd3;
`ifdef CTRL_ALU_STALL_EN
                        out_s.acc_write = 1'b0;
                        state_s         = ST_AWAIT;
`else
                        out_s.acc_write = 1'b1;
`endif
                    end
                    4'd14: begin
                        out_s.halted = 1'b1;
                        state_s      = ST_HALT;
                    end
                    4'd15: begin
                        out_s.illegal = 1'b1;
                    end
                    default: begin
                        state_s = ST_NEXT;
                    end
                endcase
            end
            ST_MWAIT: begin
                out_s.ip_write = 1'b0;
                if (mem_ready) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_MWAIT;
                end
            end
            ST_IOWAIT: begin
                if (!iobusy) begin
                    out_s.runio = 1'b0;
                    state_s     = ST_NEXT;
                end else begin
                    state_s = ST_IOWAIT;
                end
            end
            ST_NEXT: begin
                out_s.mem_read  = 1'b0;
                out_s.mem_write = 1'b0;
                out_s.ir_write  = 1'b0;
                out_s.ip_write  = 1'b0;
                out_s.acc_write = 1'b0;
                out_s.doswap    = 1'b0;
                out_s.illegal   = 1'b0;
                if (out_r.curinsn == LAST_SLOT) begin
                    out_s.curinsn = '0;
                    state_s       = ST_FETCH;
                end else begin
                    out_s.curinsn = out_r.curinsn + SLOT_W'(1);
                    state_s       = ST_DECODE;
                end
            end
            ST_HALT: begin
                out_s.mem_read  = 1'b0;
                out_s.mem_write = 1'b0;
                out_s.ir_write  = 1'b0;
                out_s.ip_write  = 1'b0;
                out_s.acc_write = 1'b0;
                out_s.doswap    = 1'b0;
                out_s.runio     = 1'b0;
                out_s.illegal   = 1'b0;
                out_s.halted    = 1'b1;
                state_s         = ST_HALT;
            end
`ifdef CTRL_ALU_STALL_EN
            ST_AWAIT: begin
                if (!alu_busy) begin
                    out_s.acc_write = 1'b1;
                    state_s         = ST_NEXT;
                end else begin
                    out_s.acc_write = 1'b0;
                    state_s         = ST_AWAIT;
                end
            end
`endif
            default: begin
                out_s   = '0;
                state_s = ST_FETCH;
            end
        endcase
    end

    // State and control-word registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_FETCH;
            out_r   <= '0;
        end else begin
            state_r <= state_s;
            out_r   <= out_s;
        end
    end

    assign mem_read  = out_r.mem_read;
    assign mem_write = out_r.mem_write;
    assign ir_write  = out_r.ir_write;
    assign ip_write  = out_r.ip_write;
    assign acc_write = out_r.acc_write;
    assign seladdr   = out_r.seladdr;
    assign selacc    = out_r.selacc;
    assign selswap   = out_r.selswap;
    assign doswap    = out_r.doswap;
    assign selip1    = out_r.selip1;
    assign selip2    = out_r.selip2;
    assign curinsn   = out_r.curinsn;
    assign aluinsn   = out_r.aluinsn;
    assign runio     = out_r.runio;
    assign halted    = out_r.halted;
    assign illegal   = out_r.illegal;

endmodule

// File: doc/sextium_ctrl_gen.md
Name: sextium_ctrl_gen

Overview:
- Parametrised next-generation Sextium III microcode controller.
- Sequences fetch, slot-by-slot decode and execute of packed 4-bit opcodes; SLOTS opcodes per fetched word.
- Adds a memory ready handshake, a HALT opcode and an illegal-opcode flag.
- Sits between the IR slot selector (driven by curinsn) and the datapath mux/strobe inputs.

Parameters:
- SLOTS, 4, opcodes per instruction word; 1..2**SLOT_W.
- SLOT_W, 2, width of curinsn; must satisfy 2**SLOT_W >= SLOTS.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- insn  in  4  opcode of the currently selected slot
- accz  in  1  ACC == 0
- accn  in  1  ACC < 0
- iobusy  in  1  IO unit busy
- mem_ready  in  1  memory access complete (sampled while waiting)
- alu_busy  in  1  ALU still computing (used only with CTRL_ALU_STALL_EN)
- mem_read, mem_write, ir_write, ip_write, acc_write  out  1  datapath strobes
- seladdr  out  1  0 = IP, 1 = AR
- selacc  out  2  0 = MEM, 1 = IO, 2 = SWAP, 3 = ALU
- selswap  out  1  0 = AR, 1 = DR
- doswap  out  1  swap strobe
- selip1  out  1  0 = next, 1 = reg
- selip2  out  1  0 = AR, 1 = ACC
- curinsn  out  SLOT_W  active slot index
- aluinsn  out  2  0 add, 1 sub, 2 mul, 3 div
- runio  out  1  IO request
- halted  out  1  core stopped
- illegal  out  1  one-cycle pulse on opcode 15

Behaviour:
- Reset
  - All outputs are registered; every output resets to 0; state resets to FETCH.
  - Reset mid-operation aborts at the next edge: all strobes drop and runio drops.
- FETCH
  - Set mem_read=1, ir_write=1, ip_write=1, seladdr=IP, selip1=NEXT, curinsn=0.
  - Go to FWAIT.
- FWAIT
  - ip_write cleared at the first FWAIT edge (exactly one IP increment per fetch).
  - Hold mem_read and ir_write until mem_ready=1 is sampled, then clear both and go to DECODE.
- DECODE, per opcode:
  - 0 NOP: go to NEXT.
  - 1 SYSCALL: runio=1, selacc=IO; go to IOWAIT.
  - 2 LOAD: mem_read, acc_write, selacc=MEM, seladdr=AR; go to MWAIT.
  - 3 STORE: mem_write, seladdr=AR; go to MWAIT.
  - 4 SWAPA / 5 SWAPD: acc_write, selacc=SWAP, doswap, selswap=AR or DR; go to NEXT.
  - 6 BRANCHZ / 7 BRANCHN:
    - If accz (resp. accn): ip_write, selip1=REG, selip2=AR, curinsn=SLOTS-1.
    - Go to NEXT either way.
  - 8 JUMP: ip_write, selip1=REG, selip2=ACC, curinsn=SLOTS-1; go to NEXT.
  - 9 CONST: mem_read, acc_write, selacc=MEM, seladdr=IP, ip_write, selip1=NEXT; go to MWAIT.
  - 10-13 ADD/SUB/MUL/DIV: aluinsn=0..3, acc_write, selacc=ALU; go to NEXT.
  - 14 HALT: halted=1; go to HALT.
  - 15: illegal=1 for one cycle; treated as NOP.
- MWAIT
  - ip_write cleared at the first MWAIT edge.
  - Hold mem_read, mem_write and acc_write until mem_ready=1, then go to NEXT.
- IOWAIT
  - When iobusy=0 is sampled: runio=0, go to NEXT.
  - iobusy already 0 on entry gives a one-cycle IOWAIT.
- NEXT
  - Clear mem_read, mem_write, ir_write, ip_write, acc_write, doswap, illegal.
  - If curinsn == SLOTS-1: curinsn=0, go to FETCH. Else curinsn+1, go to DECODE.
  - No wrap through 2**SLOT_W when SLOTS is not a power of two.
- HALT: absorbing state; halted stays 1 and all strobes stay 0 until reset.
- SLOTS=1: every instruction word is followed by FETCH; a taken branch behaves identically.

Optional Feature:
- Macro: CTRL_ALU_STALL_EN.
- Enabled:
  - MUL and DIV go from DECODE to AWAIT with acc_write=0.
  - AWAIT holds selacc=ALU and aluinsn.
  - When alu_busy=0 is sampled: acc_write=1 for exactly one cycle, then go to NEXT.
  - ADD and SUB are unaffected.
- Disabled: alu_busy is ignored and all ALU ops complete in one DECODE cycle as listed above.

Test Plan:
- Reset low for 2 cycles during MWAIT -> all outputs 0; FETCH strobes appear 1 cycle after reset release.
- Fetch word with mem_ready held low 3 cycles -> ip_write high exactly 1 cycle; mem_read and ir_write high 4 cycles; then DECODE with curinsn=0.
- Word NOP, JUMP, ADD, ADD with SLOTS=4 -> JUMP gives ip_write with selip2=1 and curinsn=3; next state FETCH; ADD slots never decoded.
- SLOTS=3, SLOT_W=2, four NOP words -> curinsn sequence 0, 1, 2, 0, ...; never 3.
- SYSCALL with iobusy high 5 cycles -> runio high through IOWAIT; drops the cycle iobusy=0 is seen; then NEXT.
- Opcode 15 then 14 -> illegal pulses 1 cycle; halted=1 permanently; no further mem_read until reset.
- With CTRL_ALU_STALL_EN: DIV with alu_busy high 4 cycles -> acc_write=0 during the stall, then a single 1-cycle acc_write with aluinsn=3.
